// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end: edge-mode codes and channel FSM encodings.
package btn_pkg;

  localparam int unsigned EDGE_PRESS   = 0;
  localparam int unsigned EDGE_RELEASE = 1;
  localparam int unsigned EDGE_BOTH    = 2;

  localparam logic [1:0] ST_REL = 2'd0;
  localparam logic [1:0] ST_PRS = 2'd1;
  localparam logic [1:0] ST_RPT = 2'd2;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, stable-count debouncer and press/repeat/release FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned ACTIVE_LOW    = 0,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned HOLD_CYCLES   = 50,
  parameter int unsigned REPEAT_CYCLES = 10
) (
  input  logic clk_d,
  input  logic rst,
  input  logic bt,
  output logic bt_level,
  output logic press_flag,
  output logic release_flag
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  if (DEB_CYCLES == 0) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end
  if (HOLD_CYCLES == 0) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES == 0) begin : g_bad_rep
    $error("REPEAT_CYCLES must be at least 1");
  end

  logic          p;
  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [1:0]    state;
  logic [HW-1:0] hcnt;
  logic          accept;
  logic          accept_press;
  logic          accept_rel;

  assign p = (ACTIVE_LOW != 0) ? ~bt : bt;

  // accept fires on the edge where bt_level itself flips, so flags line up with the level change
  assign accept       = (sync2 != bt_level) && (cnt == DEB_LAST);
  assign accept_press = accept && sync2;
  assign accept_rel   = accept && !sync2;

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      bt_level <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1 <= p;
      sync2 <= sync1;
      if (sync2 == bt_level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        bt_level <= sync2;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      state        <= ST_REL;
      hcnt         <= '0;
      press_flag   <= 1'b0;
      release_flag <= 1'b0;
    end else begin
      press_flag   <= 1'b0;
      release_flag <= 1'b0;
      case (state)
        ST_REL: begin
          hcnt <= '0;
          if (accept_press) begin
            state      <= ST_PRS;
            press_flag <= 1'b1;
          end
        end
        ST_PRS: begin
          if (accept_rel) begin
            state        <= ST_REL;
            release_flag <= 1'b1;
            hcnt         <= '0;
          end else if (REPEAT_EN != 0) begin
            if (hcnt == HOLD_LAST) begin
              state      <= ST_RPT;
              press_flag <= 1'b1;
              hcnt       <= '0;
            end else begin
              hcnt <= hcnt + HW'(1);
            end
          end
        end
        ST_RPT: begin
          // release has priority over a coinciding repeat expiry
          if (accept_rel) begin
            state        <= ST_REL;
            release_flag <= 1'b1;
            hcnt         <= '0;
          end else if (hcnt == REP_LAST) begin
            press_flag <= 1'b1;
            hcnt       <= '0;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        default: begin
          state <= ST_REL;
          hcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: independent debounced channels plus edge-mode event select.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned DEB_CYCLES    = 4,
  parameter int unsigned EDGE_MODE     = 1,
  parameter int unsigned ACTIVE_LOW    = 0,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned HOLD_CYCLES   = 50,
  parameter int unsigned REPEAT_CYCLES = 10
) (
  input  logic            clk_d,
  input  logic            rst,
  input  logic [N_CH-1:0] bt,
  output logic [N_CH-1:0] bt_level,
  output logic [N_CH-1:0] press_flag,
  output logic [N_CH-1:0] release_flag,
  output logic [N_CH-1:0] evt_flag,
  output logic            any_evt
);

  if (N_CH == 0) begin : g_bad_nch
    $error("N_CH must be at least 1");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .DEB_CYCLES   (DEB_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_EN    (REPEAT_EN),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk_d       (clk_d),
      .rst         (rst),
      .bt          (bt[i]),
      .bt_level    (bt_level[i]),
      .press_flag  (press_flag[i]),
      .release_flag(release_flag[i])
    );
  end

  // any out-of-range mode falls through to the combined press|release selection
  if (EDGE_MODE == EDGE_PRESS) begin : g_evt_press
    assign evt_flag = press_flag;
  end else if (EDGE_MODE == EDGE_RELEASE) begin : g_evt_rel
    assign evt_flag = release_flag;
  end else begin : g_evt_both
    assign evt_flag = press_flag | release_flag;
  end

  assign any_evt = |evt_flag;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: debounce latency, glitch rejection, auto-repeat, polarity and reset.
module tb_button_conditioner;

  logic       clk_d = 1'b0;
  logic       rst;
  logic [3:0] bt_a;
  logic [3:0] bt_level_a, press_flag_a, release_flag_a, evt_flag_a;
  logic       any_evt_a;
  logic [3:0] bt_b;
  logic [3:0] bt_level_b, press_flag_b, release_flag_b, evt_flag_b;
  logic       any_evt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_d = ~clk_d;

  button_conditioner #(
    .N_CH(4), .DEB_CYCLES(4), .EDGE_MODE(2), .ACTIVE_LOW(0),
    .REPEAT_EN(1), .HOLD_CYCLES(50), .REPEAT_CYCLES(10)
  ) dut_a (
    .clk_d(clk_d), .rst(rst), .bt(bt_a), .bt_level(bt_level_a),
    .press_flag(press_flag_a), .release_flag(release_flag_a),
    .evt_flag(evt_flag_a), .any_evt(any_evt_a)
  );

  button_conditioner #(
    .N_CH(4), .DEB_CYCLES(4), .EDGE_MODE(1), .ACTIVE_LOW(1),
    .REPEAT_EN(0), .HOLD_CYCLES(50), .REPEAT_CYCLES(10)
  ) dut_b (
    .clk_d(clk_d), .rst(rst), .bt(bt_b), .bt_level(bt_level_b),
    .press_flag(press_flag_b), .release_flag(release_flag_b),
    .evt_flag(evt_flag_b), .any_evt(any_evt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_d);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int npress;
    int off;
    logic pexp;

    rst  = 1'b1;
    bt_a = 4'h0;
    bt_b = 4'hF;
    repeat (3) tick();
    check_eq("rst_level_a", bt_level_a, 0);
    check_eq("rst_flags_a", {press_flag_a, release_flag_a, evt_flag_a}, 0);
    check_eq("rst_any_a", any_evt_a, 0);
    check_eq("rst_level_b", bt_level_b, 0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_flags_a", {press_flag_a, release_flag_a, any_evt_a}, 0);
    check_eq("post_rst_flags_b", {press_flag_b, release_flag_b, any_evt_b}, 0);

    // 1: press latency and release latency on ch0
    bt_a[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_eq("t1_level", bt_level_a[0], (k >= 6));
      check_eq("t1_press", press_flag_a[0], (k == 6));
      check_eq("t1_evt", evt_flag_a[0], (k == 6));
    end
    bt_a[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("t1_rel_level", bt_level_a[0], (k < 6));
      check_eq("t1_release", release_flag_a[0], (k == 6));
      check_eq("t1_rel_evt", evt_flag_a[0], (k == 6));
    end

    // 2: glitches on ch1 are rejected, then one clean 4-cycle pulse
    for (int g = 0; g < 4; g++) begin
      bt_a[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (k == 3) bt_a[1] = 1'b0;
        tick();
        check_eq("t2_glitch_level", bt_level_a[1], 0);
        check_eq("t2_glitch_press", press_flag_a[1], 0);
      end
    end
    repeat (4) begin
      tick();
      check_eq("t2_quiet_press", press_flag_a[1], 0);
    end
    npress = 0;
    bt_a[1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 4) bt_a[1] = 1'b0;
      npress += int'(press_flag_a[1]);
      check_eq("t2_press", press_flag_a[1], (k == 6));
      check_eq("t2_release", release_flag_a[1], (k == 10));
    end
    check_eq("t2_press_count", npress, 1);

    // 3+4: ch2 held then released clear of a repeat; ch3 released on a repeat expiry
    bt_a[3:2] = 2'b11;
    for (int k = 1; k <= 6 + 115; k++) begin
      tick();
      off  = k - 6;
      pexp = (off == 0) || (off >= 50 && off <= 100 && (off % 10) == 0);
      check_eq("t3_press", press_flag_a[2], pexp);
      check_eq("t3_release", release_flag_a[2], (off == 105));
      check_eq("t4_press", press_flag_a[3], pexp);
      check_eq("t4_release", release_flag_a[3], (off == 110));
      if (off == 99) bt_a[2] = 1'b0;
      if (off == 104) bt_a[3] = 1'b0;
    end
    check_eq("t4_level", bt_level_a[3:2], 0);

    // 5: active-low, release-only mode, all pins together
    bt_b = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("t5_level", bt_level_b, (k >= 6) ? 4'hF : 4'h0);
      check_eq("t5_press", press_flag_b, (k == 6) ? 4'hF : 4'h0);
      check_eq("t5_press_evt", evt_flag_b, 0);
      check_eq("t5_press_any", any_evt_b, 0);
    end
    bt_b = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("t5_release", release_flag_b, (k == 6) ? 4'hF : 4'h0);
      check_eq("t5_evt", evt_flag_b, (k == 6) ? 4'hF : 4'h0);
      check_eq("t5_any", any_evt_b, (k == 6));
    end

    // 6: reset while ch3 is auto-repeating
    bt_a[3] = 1'b1;
    repeat (6 + 55) tick();
    rst = 1'b1;
    #1;
    check_eq("t6_rst_level", bt_level_a, 0);
    check_eq("t6_rst_flags", {press_flag_a, release_flag_a, evt_flag_a}, 0);
    check_eq("t6_rst_any", any_evt_a, 0);
    repeat (2) begin
      tick();
      check_eq("t6_rst_release", release_flag_a, 0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("t6_press", press_flag_a[3], (k == 6));
      check_eq("t6_release", release_flag_a[3], 0);
      check_eq("t6_level", bt_level_a[3], (k >= 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
